// File: rtl/lock_input_pkg.sv
// Shared types and helpers for the combination-lock input conditioner.
package lock_input_pkg;

    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } btn_state_e;

    // Counter width wide enough for the larger of the two durations.
    function automatic int db_cnt_w(input int db, input int lng);
        int mx;
        mx = (db > lng) ? db : lng;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/lock_db_channel.sv
// One debounced input: two-flop synchroniser followed by a persistence counter.
// stable only follows the synchronised level after DB_CYCLES consecutive
// differing samples; busy is high while that count is in progress.
module lock_db_channel #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser for the asynchronous raw level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Accept a new level only after it persists; any bounce restarts the count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync_p1 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync_p1;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/lock_input_cond.sv
// Input conditioner ahead of the combination-lock decision logic.
// Debounces the four code switches and the try button, and turns each
// qualified press into a single try pulse with the code captured at that time.
// The try pulse is asserted in the cycle the FSM commits PRESS_DB -> HELD,
// so try_code_o shows the captured code in that same cycle.
// Optional long-press detection is built when LOCK_INPUT_LONGPRESS_EN is defined.
module lock_input_cond
    import lock_input_pkg::*;
#(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int LONG_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] sw_raw_i,
    input  logic              btn_raw_i,
    output logic [CODE_W-1:0] code_o,
    output logic              code_busy_o,
    output logic              try_o,
    output logic [CODE_W-1:0] try_code_o,
    output logic              btn_level_o,
    output logic              long_o
);

    localparam int               CNT_W   = db_cnt_w(DB_CYCLES, LONG_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CODE_W-1:0] sw_busy;
    logic              btn_p0;
    logic              btn_p1;
    btn_state_e        state;
    btn_state_e        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              try_hit;
    logic [CODE_W-1:0] try_code_q;

    for (genvar g = 0; g < CODE_W; g++) begin : g_sw
        lock_db_channel #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (sw_raw_i[g]),
            .stable (code_o[g]),
            .busy   (sw_busy[g])
        );
    end

    assign code_busy_o = |sw_busy;

    // Two-flop synchroniser for the raw button
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_p0 <= 1'b0;
            btn_p1 <= 1'b0;
        end else begin
            btn_p0 <= btn_raw_i;
            btn_p1 <= btn_p0;
        end
    end

    // Button FSM state and shared debounce counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; a press is committed only once the code is settled
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        try_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (btn_p1) begin
                    state_nxt = PRESS_DB;
                    cnt_nxt   = '0;
                end
            end
            PRESS_DB: begin
                if (!btn_p1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt != DB_LAST) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end else if (!code_busy_o) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    try_hit   = 1'b1;
                end
            end
            HELD: begin
                if (!btn_p1) begin
                    state_nxt = REL_DB;
                    cnt_nxt   = '0;
                end
            end
            REL_DB: begin
                if (btn_p1) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Hold the code that was presented with the most recent try
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            try_code_q <= '0;
        end else if (try_o) begin
            try_code_q <= code_o;
        end
    end

    assign try_o       = try_hit & rst_n;
    assign try_code_o  = try_o ? code_o : try_code_q;
    assign btn_level_o = (state == HELD) || (state == REL_DB);

`ifdef LOCK_INPUT_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_PRE  = CNT_W'(LONG_CYCLES - 2);

    logic [CNT_W-1:0] long_cnt;
    logic             long_q;

    // Time the held episode; release bounces pause it, a full release clears it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            long_cnt <= '0;
            long_q   <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if ((state == IDLE) || (state == PRESS_DB)) begin
                long_cnt <= '0;
            end else if ((state == HELD) && (long_cnt != LONG_LAST)) begin
                long_cnt <= long_cnt + CNT_W'(1);
                long_q   <= (long_cnt == LONG_PRE);
            end
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: tb/tb_lock_input_cond.sv
// Directed bench for lock_input_cond with DB_CYCLES=4, LONG_CYCLES=20.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_lock_input_cond;

    localparam int DB = 4;
    localparam int LG = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw_raw_i;
    logic       btn_raw_i;
    logic [3:0] code_o;
    logic       code_busy_o;
    logic       try_o;
    logic [3:0] try_code_o;
    logic       btn_level_o;
    logic       long_o;

    int checks = 0;
    int errors = 0;
    int tries;
    int try_k;
    int long_k;
    int longs;
    logic lvl_seen;

    always #5 clk = ~clk;

    lock_input_cond #(
        .DB_CYCLES   (DB),
        .LONG_CYCLES (LG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_raw_i    (sw_raw_i),
        .btn_raw_i   (btn_raw_i),
        .code_o      (code_o),
        .code_busy_o (code_busy_o),
        .try_o       (try_o),
        .try_code_o  (try_code_o),
        .btn_level_o (btn_level_o),
        .long_o      (long_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // 1. reset with all raw inputs high, then startup press
        rst_n     = 1'b0;
        sw_raw_i  = 4'hF;
        btn_raw_i = 1'b1;
        tick(2);
        chk("rst_code",  32'(code_o),      32'h0);
        chk("rst_busy",  32'(code_busy_o), 32'h0);
        chk("rst_try",   32'(try_o),       32'h0);
        chk("rst_tcode", 32'(try_code_o),  32'h0);
        chk("rst_lvl",   32'(btn_level_o), 32'h0);
        chk("rst_long",  32'(long_o),      32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk("t1_code", 32'(code_o), 32'((k >= 6) ? 4'hF : 4'h0));
            chk("t1_try",  32'(try_o),  32'(k == 6));
            if (k == 6) chk("t1_tcode", 32'(try_code_o), 32'hF);
            if (k == 8) chk("t1_lvl", 32'(btn_level_o), 32'h1);
        end

        // 2. release everything, then a clean switch change to 0101
        sw_raw_i  = 4'h0;
        btn_raw_i = 1'b0;
        tick(20);
        chk("t2_idle_code", 32'(code_o),      32'h0);
        chk("t2_idle_lvl",  32'(btn_level_o), 32'h0);
        sw_raw_i = 4'h5;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            chk("t2_code", 32'(code_o),      32'((k >= 6) ? 4'h5 : 4'h0));
            chk("t2_busy", 32'(code_busy_o), 32'((k >= 3) && (k <= 5)));
            chk("t2_try",  32'(try_o),       32'h0);
        end

        // 3. q bounces 1/0/1 then holds 1
        sw_raw_i = 4'hD;
        tick(1);
        sw_raw_i = 4'h5;
        tick(1);
        sw_raw_i = 4'hD;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            chk("t3_q", 32'(code_o[3]), 32'(k >= 6));
            chk("t3_low", 32'(code_o[2:0]), 32'h5);
        end

        // 4. long press with code 0101, release glitch, then re-press
        sw_raw_i = 4'h5;
        tick(10);
        chk("t4_code", 32'(code_o), 32'h5);
        btn_raw_i = 1'b1;
        tries = 0;
        for (int k = 1; k <= 50; k++) begin
            tick(1);
            if (try_o) tries++;
        end
        chk("t4_tries",  32'(tries),       32'd1);
        chk("t4_tcode",  32'(try_code_o),  32'h5);
        chk("t4_lvl",    32'(btn_level_o), 32'h1);
        tries = 0;
        btn_raw_i = 1'b0;
        tick(1);
        if (try_o) tries++;
        tick(1);
        if (try_o) tries++;
        btn_raw_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (try_o) tries++;
        end
        chk("t4_glitch_tries", 32'(tries),       32'd0);
        chk("t4_glitch_lvl",   32'(btn_level_o), 32'h1);
        btn_raw_i = 1'b0;
        tick(20);
        chk("t4_rel_lvl", 32'(btn_level_o), 32'h0);
        btn_raw_i = 1'b1;
        tries = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (try_o) tries++;
        end
        chk("t4_repress_tries", 32'(tries), 32'd1);

        // 5. short button pulse, then a press while the code is changing
        btn_raw_i = 1'b0;
        tick(20);
        btn_raw_i = 1'b1;
        tick(3);
        btn_raw_i = 1'b0;
        tries = 0;
        lvl_seen = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            if (try_o) tries++;
            lvl_seen = lvl_seen | btn_level_o;
        end
        chk("t5_short_tries", 32'(tries),    32'd0);
        chk("t5_short_lvl",   32'(lvl_seen), 32'h0);
        btn_raw_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) sw_raw_i = 4'hA;
            tick(1);
            chk("t5_try", 32'(try_o), 32'(k == 8));
            if (k == 7) chk("t5_busy", 32'(code_busy_o), 32'h1);
            if (k == 8) chk("t5_tcode", 32'(try_code_o), 32'hA);
        end
        btn_raw_i = 1'b0;
        tick(20);
        chk("t5_tcode_hold", 32'(try_code_o), 32'hA);
        chk("t5_code",       32'(code_o),     32'hA);

        // 6. hold for 32 cycles and watch the long-press output
        btn_raw_i = 1'b1;
        try_k  = 0;
        long_k = 0;
        longs  = 0;
        for (int k = 1; k <= 32; k++) begin
            tick(1);
            if (try_o) try_k = k;
            if (long_o) begin
                longs++;
                long_k = k;
            end
        end
        chk("t6_try_k", 32'(try_k), 32'd6);
`ifdef LOCK_INPUT_LONGPRESS_EN
        chk("t6_longs",  32'(longs),          32'd1);
        chk("t6_long_k", 32'(long_k - try_k), 32'd20);
`else
        chk("t6_longs",  32'(longs),  32'd0);
        chk("t6_long_k", 32'(long_k), 32'd0);
`endif
        btn_raw_i = 1'b0;
        tick(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
